// File: rtl/bounce_pkg.sv
// ----------------------------------------------------------------------------
// bounce_pkg
// Shared definitions for the switch-bounce emulator.
//   state_t    : window FSM encoding (IDLE / BOUNCE)
//   LFSR_WIDTH : width of the pattern LFSR
//   LFSR_TAPS  : Fibonacci tap mask for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
//   lfsr_next  : one LFSR step (shift left, feedback into bit 0)
// ----------------------------------------------------------------------------
package bounce_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        BOUNCE = 1'b1
    } state_t;

    localparam int                    LFSR_WIDTH = 8;
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS  = 8'hB8;

    function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] s);
        return {s[LFSR_WIDTH-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/bounce_generator_lfsr8.sv
// ----------------------------------------------------------------------------
// lfsr8
// Free-running 8-bit Fibonacci LFSR, advances on every rising Clk edge.
// Ports:
//   Clk   in   system clock
//   Reset in   asynchronous active-low reset, loads Seed
//   State out  current LFSR contents
// Parameter:
//   Seed       reset value, must be non-zero (all-zero is a lock-up state)
// ----------------------------------------------------------------------------
module lfsr8
    import bounce_pkg::*;
#(
    parameter logic [LFSR_WIDTH-1:0] Seed = 8'hA5
) (
    input  logic                  Clk,
    input  logic                  Reset,
    output logic [LFSR_WIDTH-1:0] State
);

    logic [LFSR_WIDTH-1:0] lfsr_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            lfsr_q <= Seed;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign State = lfsr_q;

endmodule

// File: rtl/bounce_generator.sv
// ----------------------------------------------------------------------------
// bounce_generator
// Switch-bounce emulator: turns a clean level into a seeded, repeatable burst
// of glitches after every input edge, then settles to the new level.
// Ports:
//   Clk       in   system clock, rising edge
//   Reset     in   asynchronous active-low reset
//   DataIn    in   clean input level
//   Enable    in   1 = inject bounce, 0 = registered pass-through
//   DataOut   out  bouncy (or passed-through) level, registered
//   Bouncing  out  high in every cycle DataOut is inside a bounce window
//   EdgeCount out  8-bit count of accepted DataIn edges (wraps 255 -> 0)
// Parameters:
//   CounterWidth  width of the window down-counter
//   BounceTime    window length in cycles (0..2^CounterWidth, 0 = no bounce)
//   LfsrSeed      LFSR reset value, non-zero
// Build option:
//   BOUNCE_EDGE_COUNT_EN  when defined, EdgeCount counts edges; otherwise the
//                         counter is omitted and EdgeCount is tied to 8'h00.
// ----------------------------------------------------------------------------
module bounce_generator
    import bounce_pkg::*;
#(
    parameter int                    CounterWidth = 4,
    parameter int                    BounceTime   = 8,
    parameter logic [LFSR_WIDTH-1:0] LfsrSeed     = 8'hA5
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       DataIn,
    input  logic       Enable,
    output logic       DataOut,
    output logic       Bouncing,
    output logic [7:0] EdgeCount
);

    // Reject parameter sets the counter or LFSR cannot represent.
    if (BounceTime < 0 || BounceTime > (1 << CounterWidth)) begin : g_bad_bounce_time
        $error("bounce_generator: BounceTime out of range for CounterWidth");
    end
    if (LfsrSeed == '0) begin : g_bad_seed
        $error("bounce_generator: LfsrSeed must be non-zero");
    end

    localparam bit                      BOUNCE_ON = (BounceTime > 0);
    localparam logic [CounterWidth-1:0] RELOAD    =
        BOUNCE_ON ? CounterWidth'(BounceTime - 1) : '0;

    state_t                  state_q, state_d;
    logic                    stable_q, stable_d;
    logic [CounterWidth-1:0] cnt_q, cnt_d;
    logic                    dout_q, dout_d;
    logic                    bounce_q, bounce_d;
    logic                    edge_seen;
    logic [LFSR_WIDTH-1:0]   lfsr_state;
    logic                    unused_lfsr;

    lfsr8 #(
        .Seed (LfsrSeed)
    ) u_lfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .State (lfsr_state)
    );

    // Only bit 0 feeds the glitch pattern.
    assign unused_lfsr = ^lfsr_state[LFSR_WIDTH-1:1];

    assign edge_seen = (DataIn != stable_q);

    // Priority: disabled/abort > edge (start or restart) > window in progress
    // > idle. Every branch that leaves the window outputs the new Stable level,
    // which is DataIn because Stable always takes DataIn on the next edge.
    always_comb begin
        stable_d = DataIn;
        state_d  = IDLE;
        cnt_d    = '0;
        dout_d   = DataIn;
        bounce_d = 1'b0;
        if (!Enable || !BOUNCE_ON) begin
            // pass-through / abort: defaults apply
        end else if (edge_seen) begin
            // first window cycle shows the new level cleanly
            state_d  = BOUNCE;
            cnt_d    = RELOAD;
            dout_d   = DataIn;
            bounce_d = 1'b1;
        end else if (state_q == BOUNCE && cnt_q != '0) begin
            state_d  = BOUNCE;
            cnt_d    = cnt_q - CounterWidth'(1);
            dout_d   = stable_q ^ lfsr_state[0];
            bounce_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            dout_q   <= 1'b0;
            bounce_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            bounce_q <= bounce_d;
        end
    end

    assign DataOut  = dout_q;
    assign Bouncing = bounce_q;

`ifdef BOUNCE_EDGE_COUNT_EN
    logic [7:0] edge_cnt_q, edge_cnt_d;

    assign edge_cnt_d = edge_seen ? edge_cnt_q + 8'd1 : edge_cnt_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            edge_cnt_q <= 8'h00;
        end else begin
            edge_cnt_q <= edge_cnt_d;
        end
    end

    assign EdgeCount = edge_cnt_q;
`else
    assign EdgeCount = 8'h00;
`endif

endmodule

// File: tb/tb_bounce_generator.sv
module tb_bounce_generator;

  localparam int BT = 3;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       din, en, din0, en0;
  logic       dout, bnc, dout0, bnc0;
  logic [7:0] ec, ec0;

  always #5 clk = ~clk;

  bounce_generator #(
    .CounterWidth (2),
    .BounceTime   (BT),
    .LfsrSeed     (8'hA5)
  ) dut (
    .Clk       (clk),
    .Reset     (rst_n),
    .DataIn    (din),
    .Enable    (en),
    .DataOut   (dout),
    .Bouncing  (bnc),
    .EdgeCount (ec)
  );

  bounce_generator #(
    .CounterWidth (2),
    .BounceTime   (0),
    .LfsrSeed     (8'hA5)
  ) dut0 (
    .Clk       (clk),
    .Reset     (rst_n),
    .DataIn    (din0),
    .Enable    (en0),
    .DataOut   (dout0),
    .Bouncing  (bnc0),
    .EdgeCount (ec0)
  );

  // ---------------- bookkeeping ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int exp_ec(input int count);
`ifdef BOUNCE_EDGE_COUNT_EN
    return count;
`else
    return 0 * count;
`endif
  endfunction

  // ---------------- reference model ----------------
  // Window modelled as "cycles of bounce still owed"; LFSR stepped from its
  // polynomial exponents.
  logic       m_stable;
  int         m_left;
  int         m_pos;
  logic [7:0] m_lfsr;
  int         m_ec;
  logic [9:0] exp_q[$];

  function automatic logic [7:0] poly_step(input logic [7:0] s);
    int   expo[4] = '{8, 6, 5, 4};
    logic fb = 1'b0;
    foreach (expo[k]) fb ^= s[expo[k]-1];
    return {s[6:0], fb};
  endfunction

  task automatic model_reset();
    m_stable = 1'b0;
    m_left   = 0;
    m_pos    = 0;
    m_lfsr   = 8'hA5;
    m_ec     = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic d, input logic e);
    logic edg, o, b;
    edg      = (d != m_stable);
    m_stable = d;
    if (edg) m_ec = (m_ec + 1) % 256;
    if (!e) m_left = 0;
    else if (edg) begin
      m_left = BT;
      m_pos  = 0;
    end
    if (m_left > 0) begin
      o = (m_pos == 0) ? m_stable : (m_stable ^ m_lfsr[0]);
      b = 1'b1;
      m_pos++;
      m_left--;
    end else begin
      o = m_stable;
      b = 1'b0;
    end
    m_lfsr = poly_step(m_lfsr);
    exp_q.push_back({o, b, 8'(exp_ec(m_ec))});
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_model(input logic d, input logic e, input string tag);
    logic [9:0] x;
    din = d;
    en  = e;
    model_step(d, e);
    cycle();
    x = exp_q.pop_front();
    check({tag, " dout"}, dout, x[9]);
    check({tag, " bouncing"}, bnc, x[8]);
    check({tag, " edgecount"}, ec, x[7:0]);
  endtask

  task automatic do_reset();
    din  = 1'b0;
    en   = 1'b0;
    din0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int din;
    int en;
    int chk_d;
    int dout;
    int bnc;
    int ec;
  } vec_t;

  vec_t tbl[26];

  initial begin
    tbl = '{
      // pass-through with Enable=0
      '{0, 0, 1, 0, 0, 0}, '{1, 0, 1, 1, 0, 1}, '{1, 0, 1, 1, 0, 1}, '{0, 0, 1, 0, 0, 2},
      // rise held with Enable=1: window of BT cycles, then clean
      '{0, 1, 1, 0, 0, 2}, '{1, 1, 1, 1, 1, 3}, '{1, 1, 0, 0, 1, 3}, '{1, 1, 0, 0, 1, 3},
      '{1, 1, 1, 1, 0, 3}, '{1, 1, 1, 1, 0, 3}, '{1, 1, 1, 1, 0, 3}, '{1, 1, 1, 1, 0, 3},
      // restart: rise then fall in window cycle 2 -> 5 bouncing cycles
      '{0, 0, 1, 0, 0, 4}, '{1, 1, 1, 1, 1, 5}, '{1, 1, 0, 0, 1, 5}, '{0, 1, 1, 0, 1, 6},
      '{0, 1, 0, 0, 1, 6}, '{0, 1, 0, 0, 1, 6}, '{0, 1, 1, 0, 0, 6}, '{0, 1, 1, 0, 0, 6},
      // Enable fall aborts; Enable rise without edge starts nothing
      '{1, 1, 1, 1, 1, 7}, '{1, 0, 1, 1, 0, 7}, '{1, 1, 1, 1, 0, 7},
      // edge together with Enable fall: abort wins, edge still counted
      '{0, 1, 1, 0, 1, 8}, '{1, 0, 1, 1, 0, 9}, '{1, 1, 1, 1, 0, 9}
    };

    din   = 1'b0;
    en    = 1'b0;
    din0  = 1'b0;
    en0   = 1'b1;
    rst_n = 1'b0;

    // reset values before any clock edge
    #1;
    check("reset dout", dout, 0);
    check("reset bouncing", bnc, 0);
    check("reset edgecount", ec, 0);
    check("reset dout0", dout0, 0);
    check("reset bouncing0", bnc0, 0);
    check("reset edgecount0", ec0, 0);

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 26; i++) begin
      din = tbl[i].din[0];
      en  = tbl[i].en[0];
      cycle();
      if (tbl[i].chk_d != 0) check($sformatf("vec%0d dout", i), dout, tbl[i].dout);
      check($sformatf("vec%0d bouncing", i), bnc, tbl[i].bnc);
      check($sformatf("vec%0d edgecount", i), ec, exp_ec(tbl[i].ec));
    end

    // reset pulsed in window cycle 2, then identical replay from fresh seed
    do_reset();
    drive_model(1'b0, 1'b1, "rstA0");
    drive_model(1'b1, 1'b1, "rstA1");
    drive_model(1'b1, 1'b1, "rstA2");
    rst_n = 1'b0;
    #1;
    check("midwin reset dout", dout, 0);
    check("midwin reset bouncing", bnc, 0);
    check("midwin reset edgecount", ec, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drive_model(1'b0, 1'b1, "rstB0");
    drive_model(1'b1, 1'b1, "rstB1");
    for (int i = 0; i < 8; i++) drive_model(1'b1, 1'b1, $sformatf("rstB%0d", i + 2));

    // randomized stimulus against the model
    do_reset();
    begin
      logic d;
      d = 1'b0;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 3) == 0) d = ~d;
        drive_model(d, ($urandom_range(0, 9) != 0), $sformatf("rnd%0d", i));
      end
    end

    // BounceTime=0 instance: pure 1-cycle delay, 256 edges wrap the counter
    do_reset();
    for (int i = 0; i < 256; i++) begin
      logic prev;
      din0 = ~din0;
      prev = din0;
      cycle();
      check($sformatf("bt0 dout %0d", i), dout0, prev);
      check($sformatf("bt0 bouncing %0d", i), bnc0, 0);
      if (i == 254) check("bt0 edgecount 255", ec0, exp_ec(255));
    end
    check("bt0 edgecount wrap", ec0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bounce_generator.md
# bounce_generator

Synthesisable switch-bounce emulator: the inverse of the Debouncer. Takes a clean level on DataIn and drives DataOut with a pseudo-random burst of glitches after every input edge before settling to the new level. It sits in front of the Debouncer in on-board self-test builds and in benches, so that debounce logic is exercised with repeatable, seeded bounce patterns instead of hand-written toggles.

## Interface
- CounterWidth, 4: width of the bounce-window down-counter.
- BounceTime, 8: bounce window length in Clk cycles. Legal range is 0..2^CounterWidth. A value of 0 disables bouncing.
- LfsrSeed, 8'hA5: LFSR reset value. Must be non-zero.
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- DataIn  in  1  clean input level.
- Enable  in  1  1 = bounce injection on; 0 = registered pass-through.
- DataOut  out  1  bouncy (or passed-through) level, registered.
- Bouncing  out  1  high for every cycle in which DataOut is inside a bounce window.
- EdgeCount  out  8  count of accepted DataIn edges (see Configuration).

## Operation
- Internal registers:
  - Stable: last accepted DataIn level.
  - Cnt: CounterWidth bits.
  - 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
  - State in {IDLE, BOUNCE}.
- The LFSR advances every cycle in every state, including IDLE and when Enable=0. It is free-running, so patterns are deterministic from reset.
- Edge detect: an edge is accepted when DataIn != Stable. On an accepted edge, Stable <= DataIn and EdgeCount increments.
- IDLE:
  - DataOut <= Stable, Bouncing <= 0.
  - If an edge is accepted, Enable=1 and BounceTime>0: Cnt <= BounceTime-1, State <= BOUNCE.
- BOUNCE:
  - Bouncing <= 1.
  - First window cycle: DataOut <= new Stable.
  - Later window cycles: DataOut <= Stable ^ lfsr[0].
  - Cnt decrements each cycle. When Cnt==0, the next cycle is IDLE with DataOut = Stable.
- Edge during BOUNCE: window restarts. Stable <= DataIn, Cnt <= BounceTime-1, first-cycle rule applies again.
- Enable falling during BOUNCE: window aborts. Next cycle DataOut = Stable, Bouncing = 0, State = IDLE.
- Enable=0: DataOut follows DataIn with a 1-cycle delay, Bouncing = 0, and no window starts. Enable rising without an edge starts nothing.

## Timing
- Reset values: DataOut=0, Bouncing=0, EdgeCount=0, Stable=0, Cnt=0, State=IDLE, LFSR=LfsrSeed. All apply immediately on Reset low, independent of Clk.
- Reset asserted mid-window aborts the window. After release, the block behaves as freshly reset.
- DataIn edge to first DataOut change: 1 cycle.
- Bouncing is high for exactly BounceTime consecutive cycles per non-restarted window, starting 1 cycle after the edge.
- DataOut is guaranteed equal to Stable from cycle BounceTime+1 after the last edge onward.
- Simultaneous edge and Enable fall: the abort wins. Stable still updates and EdgeCount still increments.
- Cnt reload value BounceTime-1 must fit in CounterWidth bits. An out-of-range parameter is an elaboration error.

## Configuration
- BOUNCE_EDGE_COUNT_EN defined: EdgeCount is an 8-bit counter of accepted edges. It wraps 255 -> 0.
- Not defined: the counter logic is omitted and EdgeCount is tied to 8'h00. The port remains present.

## Structure
- Package bounce_pkg holds:
  - typedef enum state_t {IDLE, BOUNCE}.
  - LFSR_WIDTH = 8.
  - LFSR_TAPS = 8'hB8.
- Sub-module lfsr8: Clk, Reset, seed parameter, 8-bit state output, always-advance. It is instantiated once.

## Test plan
All scenarios use CounterWidth=2, BounceTime=3, LfsrSeed=8'hA5 and BOUNCE_EDGE_COUNT_EN defined, except scenario 6.
- Reset low at t=0 -> DataOut=0, Bouncing=0, EdgeCount=0 before any Clk edge.
- Enable=0, DataIn 0->1 -> DataOut=1 after 1 cycle; Bouncing stays 0; EdgeCount=1.
- Enable=1, DataIn 0->1 held 10 cycles:
  - DataOut=1 one cycle after the edge.
  - Bouncing high cycles 1-3.
  - DataOut=1 from cycle 4 onward.
  - The output fed into Debouncer(CounterWidth=2, DebounceTime=3) yields one clean rise.
- Enable=1, DataIn 0->1 then 1->0 in cycle 2 -> window restarts; Bouncing is high 5 consecutive cycles total; final DataOut=0; EdgeCount=2.
- Reset pulsed low in window cycle 2 -> DataOut=0 and Bouncing=0 immediately. After release, the same stimulus reproduces an identical DataOut sequence (LFSR reseeded).
- BounceTime=0 instance, Enable=1, 256 DataIn edges -> DataOut equals DataIn delayed 1 cycle; Bouncing never high; EdgeCount wraps to 0.
